// File: rtl/mod_n_sequencer.sv
// Run controller for a programmable mod-N count sequence with start/pause/abort control.
// Optional prescaler enabled by defining MOD_N_SEQ_PRESCALER_EN (adds cfg_div input).
module mod_n_sequencer #(
    parameter int MAX_N   = 16,
    parameter int REP_W   = 8,
    parameter int PRESC_W = 4,
    localparam int CW     = $clog2(MAX_N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CW-1:0]      cfg_n,
    input  logic [REP_W-1:0]   cfg_reps,
`ifdef MOD_N_SEQ_PRESCALER_EN
    input  logic [PRESC_W-1:0] cfg_div,
`endif
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [CW-1:0]      count,
    output logic               wrap,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] MAX_N_C = CW'(MAX_N);

    state_t             state, state_nxt;
    logic [CW-1:0]      count_nxt;
    logic [CW-1:0]      n_lat, n_nxt;
    logic [REP_W-1:0]   reps_lat, reps_nxt;
    logic [REP_W-1:0]   rep_cnt, rep_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic [PRESC_W-1:0] div_lat;
    logic               wrap_nxt, busy_nxt, done_nxt, err_nxt;
    logic               cfg_legal, launch, step;

    assign cfg_legal = (cfg_n != '0) && (cfg_n <= MAX_N_C);
    // Abort outranks start, so a launch only happens on a clean IDLE start.
    assign launch    = (state == S_IDLE) && start && !abort && cfg_legal;
    assign step      = (presc == div_lat);
    assign state_dbg = state;

`ifdef MOD_N_SEQ_PRESCALER_EN
    logic [PRESC_W-1:0] div_nxt;

    always_comb begin
        div_nxt = div_lat;
        if (launch) begin
            div_nxt = cfg_div;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_lat <= '0;
        end else begin
            div_lat <= div_nxt;
        end
    end
`else
    // Without the prescaler the divider is zero, so every RUN cycle is a step.
    assign div_lat = '0;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        n_nxt     = n_lat;
        reps_nxt  = reps_lat;
        rep_nxt   = rep_cnt;
        presc_nxt = presc;
        wrap_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        if (abort) begin
            state_nxt = S_IDLE;
            count_nxt = '0;
            presc_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_legal) begin
                            n_nxt     = cfg_n;
                            reps_nxt  = cfg_reps;
                            rep_nxt   = '0;
                            count_nxt = '0;
                            presc_nxt = '0;
                            state_nxt = S_RUN;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_nxt = S_PAUSE;
                    end else if (!step) begin
                        presc_nxt = presc + PRESC_W'(1);
                    end else begin
                        presc_nxt = '0;
                        if (count == n_lat - CW'(1)) begin
                            count_nxt = '0;
                            wrap_nxt  = 1'b1;
                            if (rep_cnt != '1) begin
                                rep_nxt = rep_cnt + REP_W'(1);
                            end
                            if ((reps_lat != '0) && (rep_cnt == reps_lat - REP_W'(1))) begin
                                state_nxt = S_DONE;
                            end
                        end else begin
                            count_nxt = count + CW'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    done_nxt  = 1'b1;
                    count_nxt = '0;
                    presc_nxt = '0;
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                end
            endcase
        end

        busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            n_lat    <= '0;
            reps_lat <= '0;
            rep_cnt  <= '0;
            presc    <= '0;
            wrap     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            n_lat    <= n_nxt;
            reps_lat <= reps_nxt;
            rep_cnt  <= rep_nxt;
            presc    <= presc_nxt;
            wrap     <= wrap_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            cfg_err  <= err_nxt;
        end
    end

endmodule
